branch_flag_unit: RTL and testbench

Parametrised branch-resolution unit for the K2 execute stage. It holds a registered flag file (Z, C, N, V) updated from the ALU, evaluates an 8-way condition code, and adds a hardware loop counter. It issues a registered taken pulse plus a pipeline flush window of configurable length, and is the successor to the combinational jump-on-carry/zero logic.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/cond_eval.sv | 25 ++
 rtl/branch_flag_unit.sv | 126 ++++++++++++
 tb/tb_branch_flag_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch-resolution unit: condition codes and flag bit positions.
package branch_pkg;

    typedef enum logic [2:0] {
        ALWAYS = 3'd0,
        EQ     = 3'd1,
        NE     = 3'd2,
        CS     = 3'd3,
        CC     = 3'd4,
        MI     = 3'd5,
        VS     = 3'd6,
        LOOP   = 3'd7
    } cond_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: decides whether a branch with the given code is taken.
module cond_eval
    import branch_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] flags,
    input  logic       cnt_nonzero_after_dec,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        unique case (cond)
            ALWAYS: take = 1'b1;
            EQ:     take = flags[FLAG_Z];
            NE:     take = ~flags[FLAG_Z];
            CS:     take = flags[FLAG_C];
            CC:     take = ~flags[FLAG_C];
            MI:     take = flags[FLAG_N];
            VS:     take = flags[FLAG_V];
            LOOP:   take = cnt_nonzero_after_dec;
        endcase
    end

endmodule

// File: rtl/branch_flag_unit.sv
// Execute-stage branch resolution: flag file, loop counter, registered taken pulse and
// a flush window that squashes the instructions fetched behind a taken branch.
module branch_flag_unit
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_ovf,
    input  logic                 flag_we,
    input  logic                 br_valid,
    input  logic [2:0]           br_cond,
    input  logic                 cnt_load,
    input  logic [CNT_WIDTH-1:0] cnt_value,
    output logic [3:0]           flags,
    output logic [CNT_WIDTH-1:0] loop_cnt,
    output logic                 br_taken,
    output logic                 flush
);

    localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e               state_q, state_d;
    logic [FlushW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [3:0]           flags_q, flags_d;
    logic [CNT_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
    logic                 br_taken_q, br_taken_d;

    cond_e                cond;
    logic [3:0]           new_flags;
    logic [CNT_WIDTH-1:0] cnt_dec;
    logic                 cnt_nonzero;
    logic                 cnt_nonzero_after_dec;
    logic                 accept;
    logic                 is_loop;
    logic                 cond_take;
    logic                 take;

    assign cond = cond_e'(br_cond);

    always_comb begin
        new_flags         = 4'b0000;
        new_flags[FLAG_Z] = (alu_result == '0);
        new_flags[FLAG_N] = alu_result[WIDTH-1];
        new_flags[FLAG_C] = alu_carry;
        new_flags[FLAG_V] = alu_ovf;
    end

    // Branches see this cycle's flags when they are being written (forwarding).
    assign flags_d = flag_we ? new_flags : flags_q;

    assign cnt_dec               = loop_cnt_q - CNT_WIDTH'(1);
    assign cnt_nonzero           = (loop_cnt_q != '0);
    assign cnt_nonzero_after_dec = cnt_nonzero && (cnt_dec != '0);

    cond_eval u_cond_eval (
        .cond                  (cond),
        .flags                 (flags_d),
        .cnt_nonzero_after_dec (cnt_nonzero_after_dec),
        .take                  (cond_take)
    );

    // Branches arriving inside a flush window belong to squashed instructions.
    assign accept  = br_valid && (state_q == StIdle);
    assign is_loop = accept && (cond == LOOP);
    assign take    = accept && cond_take && !(cnt_load && cond == LOOP);

    always_comb begin
        loop_cnt_d = loop_cnt_q;
        if (cnt_load) begin
            loop_cnt_d = cnt_value;
        end else if (is_loop && cnt_nonzero) begin
            loop_cnt_d = cnt_dec;
        end
    end

    always_comb begin
        br_taken_d  = take;
        flush_cnt_d = flush_cnt_q;
        state_d     = state_q;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    flush_cnt_d = FlushW'(FLUSH_CYCLES);
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q - FlushW'(1);
                if (flush_cnt_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            flags_q     <= 4'b0000;
            loop_cnt_q  <= '0;
            br_taken_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            flags_q     <= flags_d;
            loop_cnt_q  <= loop_cnt_d;
            br_taken_q  <= br_taken_d;
        end
    end

    assign flags    = flags_q;
    assign loop_cnt = loop_cnt_q;
    assign br_taken = br_taken_q;
    assign flush    = (state_q == StFlush);

endmodule

// File: tb/tb_branch_flag_unit.sv
// Bench for branch_flag_unit: directed scenarios plus random traffic, all checked against
// a cycle-level reference model of the flag/loop/flush rules.
module tb_branch_flag_unit;

    localparam int W  = 8;
    localparam int CW = 8;
    localparam int FC = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  alu_result;
    logic          alu_carry;
    logic          alu_ovf;
    logic          flag_we;
    logic          br_valid;
    logic [2:0]    br_cond;
    logic          cnt_load;
    logic [CW-1:0] cnt_value;
    logic [3:0]    flags;
    logic [CW-1:0] loop_cnt;
    logic          br_taken;
    logic          flush;

    always #5 clk = ~clk;

    branch_flag_unit #(
        .WIDTH        (W),
        .CNT_WIDTH    (CW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_ovf    (alu_ovf),
        .flag_we    (flag_we),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .cnt_load   (cnt_load),
        .cnt_value  (cnt_value),
        .flags      (flags),
        .loop_cnt   (loop_cnt),
        .br_taken   (br_taken),
        .flush      (flush)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: flags as {V,N,C,Z}, counter, remaining flush cycles, last taken.
    logic [3:0] m_flags = 4'b0;
    int         m_cnt   = 0;
    int         m_left  = 0;
    bit         m_taken = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input int c, input logic [3:0] f, input int cnt,
                                      input bit ld);
        case (c)
            0: return 1'b1;
            1: return f[0];
            2: return !f[0];
            3: return f[1];
            4: return !f[1];
            5: return f[2];
            6: return f[3];
            default: return !ld && cnt > 0 && (cnt - 1) > 0;
        endcase
    endfunction

    task automatic model_update();
        logic [3:0] nf;
        bit accept;
        bit taken;
        if (reset) begin
            m_flags = 4'b0;
            m_cnt   = 0;
            m_left  = 0;
            m_taken = 1'b0;
        end else begin
            nf = flag_we ? {alu_ovf, alu_result[W-1], alu_carry, alu_result == 0} : m_flags;
            accept = br_valid && (m_left == 0);
            taken  = accept && cond_holds(int'(br_cond), nf, m_cnt, cnt_load);
            if (cnt_load) m_cnt = int'(cnt_value);
            else if (accept && br_cond == 3'd7 && m_cnt > 0) m_cnt = m_cnt - 1;
            m_left  = taken ? FC : (m_left > 0 ? m_left - 1 : 0);
            m_flags = nf;
            m_taken = taken;
        end
    endtask

    task automatic step(input bit rst, input bit we, input logic [W-1:0] res, input bit c,
                        input bit v, input bit bv, input logic [2:0] cond, input bit ld,
                        input logic [CW-1:0] val);
        reset      = rst;
        flag_we    = we;
        alu_result = res;
        alu_carry  = c;
        alu_ovf    = v;
        br_valid   = bv;
        br_cond    = cond;
        cnt_load   = ld;
        cnt_value  = val;
        @(posedge clk);
        model_update();
        #1;
        check("model_flags", 32'(flags), 32'(m_flags));
        check("model_loop_cnt", 32'(loop_cnt), 32'(m_cnt));
        check("model_br_taken", 32'(br_taken), 32'(m_taken));
        check("model_flush", 32'(flush), 32'(m_left > 0));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0);
    endtask

    task automatic branch(input logic [2:0] cond);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, cond, 1'b0, '0);
    endtask

    initial begin
        // Reset then idle
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0);
        idle();
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_loop_cnt", 32'(loop_cnt), 32'h0);
        check("reset_br_taken", 32'(br_taken), 32'h0);
        check("reset_flush", 32'(flush), 32'h0);

        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, '0);
        check("capture_zero_carry", 32'(flags), 32'h3);

        // Forwarding: registered Z cleared, EQ branch sees the same-cycle Z
        step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0);
        check("z_cleared", 32'(flags), 32'h0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, '0);
        check("fwd_eq_taken", 32'(br_taken), 32'h1);
        check("fwd_eq_flush", 32'(flush), 32'h1);
        idle();
        check("taken_one_cycle", 32'(br_taken), 32'h0);
        check("flush_cycle2", 32'(flush), 32'h1);
        idle();
        check("flush_cycle3", 32'(flush), 32'h1);
        idle();
        check("flush_ends", 32'(flush), 32'h0);

        // LOOP counting down from 3
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'd3);
        check("loop_load", 32'(loop_cnt), 32'd3);
        branch(3'd7);
        check("loop1_taken", 32'(br_taken), 32'h1);
        check("loop1_cnt", 32'(loop_cnt), 32'd2);
        repeat (FC) idle();
        branch(3'd7);
        check("loop2_taken", 32'(br_taken), 32'h1);
        check("loop2_cnt", 32'(loop_cnt), 32'd1);
        repeat (FC) idle();
        branch(3'd7);
        check("loop3_not_taken", 32'(br_taken), 32'h0);
        check("loop3_cnt", 32'(loop_cnt), 32'd0);
        branch(3'd7);
        check("loop4_not_taken", 32'(br_taken), 32'h0);
        check("loop4_no_wrap", 32'(loop_cnt), 32'd0);

        // Squash inside the flush window
        branch(3'd0);
        check("squash_first_taken", 32'(br_taken), 32'h1);
        branch(3'd0);
        check("squash_a_taken", 32'(br_taken), 32'h0);
        check("squash_a_flush", 32'(flush), 32'h1);
        branch(3'd0);
        check("squash_b_taken", 32'(br_taken), 32'h0);
        check("squash_b_flush", 32'(flush), 32'h1);
        branch(3'd0);
        check("squash_c_taken", 32'(br_taken), 32'h0);
        check("squash_c_flush", 32'(flush), 32'h0);
        branch(3'd0);
        check("accept_after_window", 32'(br_taken), 32'h1);
        repeat (FC) idle();

        // cnt_load beats a same-cycle LOOP
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'd2);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 8'd5);
        check("prio_cnt", 32'(loop_cnt), 32'd5);
        check("prio_not_taken", 32'(br_taken), 32'h0);

        // Reset during a flush window
        step(1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, '0);
        check("pre_reset_flags", 32'(flags), 32'he);
        idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, '0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_cnt", 32'(loop_cnt), 32'h0);
        check("rst_taken", 32'(br_taken), 32'h0);
        idle();
        check("post_rst_taken", 32'(br_taken), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? '0 : W'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 7) == 0,
                 CW'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
